// File: rtl/bcd_serial_adder_pkg.sv
// Shared constants and state encoding for the digit-serial BCD adder.
package bcd_serial_adder_pkg;
  localparam int DIGIT_W = 4;
  localparam int BCD_MAX = 9;
  localparam int BCD_ADJ = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit decimal add: a_d + b_d + c_in -> BCD digit and carry.
module bcd_digit_add
  import bcd_serial_adder_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       c_in,
  output logic [3:0] s_d,
  output logic       c_out
);

  // Folds a binary digit sum back into BCD; non-BCD inputs keep only the low nibble.
  function automatic logic [4:0] bcd_adjust(input logic [5:0] t);
    logic [5:0] adj;
    adj = t + 6'(BCD_ADJ);
    if (t > 6'(BCD_MAX))
      return {1'b1, adj[3:0]};
    else
      return {1'b0, t[3:0]};
  endfunction

  logic [5:0] t;
  logic [4:0] res;

  always_comb begin
    t     = 6'(a_d) + 6'(b_d) + 6'(c_in);
    res   = bcd_adjust(t);
    s_d   = res[3:0];
    c_out = res[4];
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder: latches two packed operands on start, adds one digit per clock LSB first.
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  invalid
);

  localparam int W = DIGIT_W * DIGITS;

  state_t        state, state_nx;
  logic [W-1:0]  a_sh, b_sh, res;
  logic          carry;
  logic [3:0]    cnt;

  logic [3:0]    s_d;
  logic          c_out;
  logic [W+3:0]  res_cat;
  logic [W-1:0]  res_nx;
  logic          last;
  logic          bad_d;

  bcd_digit_add u_digit (
    .a_d   (a_sh[3:0]),
    .b_d   (b_sh[3:0]),
    .c_in  (carry),
    .s_d   (s_d),
    .c_out (c_out)
  );

  always_comb begin
    res_cat = {s_d, res};
    res_nx  = res_cat[W+3:4];
    last    = (cnt == 4'(DIGITS - 1));
    bad_d   = (a_sh[3:0] > 4'(BCD_MAX)) || (b_sh[3:0] > 4'(BCD_MAX));
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = ADD;
      ADD: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      res     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          a_sh    <= a;
          b_sh    <= b;
          carry   <= cin;
          cnt     <= '0;
          invalid <= 1'b0;
        end
        ADD: begin
          a_sh    <= a_sh >> DIGIT_W;
          b_sh    <= b_sh >> DIGIT_W;
          res     <= res_nx;
          carry   <= c_out;
          cnt     <= cnt + 4'd1;
          invalid <= invalid | bad_d;
          if (last) begin
            sum  <= res_nx;
            cout <= c_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder with DIGITS=4.
module tb_bcd_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout, invalid;
  logic [15:0] sum;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.DIGITS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .invalid (invalid)
  );

  // Presents operands with start for one edge, then scrambles the inputs.
  task automatic launch(input logic [15:0] ta, input logic [15:0] tb_, input logic tc);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'hFFFF; b = 16'hFFFF; cin = ~tc;
  endtask

  // Returns at the negedge inside the done cycle, or after a bounded wait.
  task automatic wait_done(output int busy_cyc, output bit got);
    busy_cyc = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy, done, cout, invalid} !== 4'b0000 || sum !== 16'h0000) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b sum=%h cout=%b inv=%b, want all zero",
               busy, done, sum, cout, invalid);
    end
  endtask

  task automatic test_basic;
    int bc; bit got;
    launch(16'h1234, 16'h5678, 1'b0);
    wait_done(bc, got);
    total++;
    if (!got) begin bad++; $display("FAIL basic_timeout: done never seen, want done"); end
    total++;
    if (bc !== 4) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 4", bc); end
    total++;
    if (sum !== 16'h6912 || cout !== 1'b0 || invalid !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: sum=%h cout=%b inv=%b want 6912/0/0", sum, cout, invalid);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_in_done: got %b want 0", busy); end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width: got %b want 0", done); end
  endtask

  task automatic test_carry;
    int bc; bit got;
    launch(16'h9999, 16'h0001, 1'b0);
    wait_done(bc, got);
    total++;
    if (!got || sum !== 16'h0000 || cout !== 1'b1) begin
      bad++;
      $display("FAIL carry_9999: got=%b sum=%h cout=%b want 1/0000/1", got, sum, cout);
    end
    repeat (3) @(negedge clk);
    total++;
    if (sum !== 16'h0000 || cout !== 1'b1) begin
      bad++;
      $display("FAIL carry_hold_idle: sum=%h cout=%b want 0000/1", sum, cout);
    end
    launch(16'h0000, 16'h0000, 1'b1);
    total++;
    if (sum !== 16'h0000 || cout !== 1'b1) begin
      bad++;
      $display("FAIL carry_hold_add: sum=%h cout=%b want 0000/1", sum, cout);
    end
    wait_done(bc, got);
    total++;
    if (!got || sum !== 16'h0001 || cout !== 1'b0) begin
      bad++;
      $display("FAIL carry_cin: got=%b sum=%h cout=%b want 1/0001/0", got, sum, cout);
    end
  endtask

  task automatic test_boundary;
    int bc; bit got;
    launch(16'h5000, 16'h5000, 1'b0);
    wait_done(bc, got);
    total++;
    if (!got || sum !== 16'h0000 || cout !== 1'b1) begin
      bad++;
      $display("FAIL msd_carry: got=%b sum=%h cout=%b want 1/0000/1", got, sum, cout);
    end
    launch(16'h0009, 16'h0009, 1'b1);
    wait_done(bc, got);
    total++;
    if (!got || sum !== 16'h0019 || cout !== 1'b0) begin
      bad++;
      $display("FAIL nine_nine_cin: got=%b sum=%h cout=%b want 1/0019/0", got, sum, cout);
    end
  endtask

  task automatic test_invalid;
    int bc; bit got;
    launch(16'h00A0, 16'h0000, 1'b0);
    wait_done(bc, got);
    total++;
    if (!got || invalid !== 1'b1 || sum !== 16'h0100 || cout !== 1'b0) begin
      bad++;
      $display("FAIL invalid_set: got=%b inv=%b sum=%h cout=%b want 1/1/0100/0",
               got, invalid, sum, cout);
    end
    launch(16'h1111, 16'h1111, 1'b0);
    wait_done(bc, got);
    total++;
    if (!got || invalid !== 1'b0 || sum !== 16'h2222) begin
      bad++;
      $display("FAIL invalid_clear: got=%b inv=%b sum=%h want 1/0/2222", got, invalid, sum);
    end
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    bit overlap = 1'b0;
    bit got = 1'b0;
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 16'h9999; b = 16'h9999; cin = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (busy && done) overlap = 1'b1;
      if (done) begin
        pulses++;
        got = 1'b1;
        total++;
        if (sum !== 16'h6912 || cout !== 1'b0) begin
          bad++;
          $display("FAIL b2b_result: sum=%h cout=%b want 6912/0", sum, cout);
        end
        start = 1'b0;
        break;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy && done) overlap = 1'b1;
      if (done || busy) pulses++;
    end
    total++;
    if (!got || pulses !== 1) begin
      bad++;
      $display("FAIL b2b_pulses: got=%b activity=%0d want 1/1", got, pulses);
    end
    total++;
    if (overlap) begin bad++; $display("FAIL b2b_overlap: busy&done seen, want never"); end
  endtask

  task automatic test_reset_mid;
    int bc; bit got;
    int stray = 0;
    launch(16'h1234, 16'h5678, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy, done, cout, invalid} !== 4'b0000 || sum !== 16'h0000) begin
      bad++;
      $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b inv=%b want all zero",
               busy, done, sum, cout, invalid);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    total++;
    if (stray !== 0) begin bad++; $display("FAIL reset_no_done: activity=%0d want 0", stray); end
    a = 16'h1234; b = 16'h5678; rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_beats_start: busy=%b want 0", busy); end
    launch(16'h0009, 16'h0009, 1'b1);
    wait_done(bc, got);
    total++;
    if (!got || sum !== 16'h0019 || cout !== 1'b0) begin
      bad++;
      $display("FAIL reset_recover: got=%b sum=%h cout=%b want 1/0019/0", got, sum, cout);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_boundary;
    test_invalid;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
